uart_tx_stim: RTL and testbench



---
 rtl/uart_tx_stim.sv | 181 ++++++++++++++++++
 tb/tb_uart_tx_stim.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_stim.sv
// Bench-side UART transmitter: 8-deep byte FIFO feeding an 8N1 serialiser; tx_out falls 1 clock after a push into an idle block, and pushes are refused while the FIFO is full.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1 frames).
module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 3,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  output logic               tx_out,
  output logic               busy,
  output logic               frame_done,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]    BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]    BIT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      cnt;
  logic [2:0]         bit_idx;
  logic               stop_idx;
  logic [7:0]         shift;
`ifdef UART_TX_PARITY_EN
  logic               par;
`endif

  logic       push;
  logic       pop;
  logic       bit_end;
  logic       stop_last;
  logic [7:0] head;

  assign tx_ready  = (fifo_count != FULL);
  assign busy      = (state != IDLE) || (fifo_count != '0);
  assign push      = tx_valid && tx_ready;
  assign bit_end   = (cnt == BIT_LAST);
  assign stop_last = (stop_idx == 1'(STOP_BITS - 1));
  assign head      = mem[rd_ptr];
  // Pop decisions use the registered count, so a same-edge push is not visible yet.
  assign pop = (fifo_count != '0) &&
               ((state == IDLE) || (state == STOP && bit_end && stop_last));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      frame_done <= 1'b0;
      cnt        <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          cnt    <= '0;
          if (pop) begin
            shift   <= head;
            bit_idx <= '0;
            state   <= START;
            tx_out  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par     <= ^head;
`endif
          end
        end
        START: begin
          if (bit_end) begin
            cnt    <= '0;
            state  <= DATA;
            tx_out <= shift[0];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state    <= PARITY;
              tx_out   <= par;
`else
              state    <= STOP;
              tx_out   <= 1'b1;
              stop_idx <= 1'b0;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx_out  <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt      <= '0;
            state    <= STOP;
            tx_out   <= 1'b1;
            stop_idx <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          // Raised one cycle early so the pulse covers the last stop cycle itself.
          if (stop_last && cnt == BIT_PRE) frame_done <= 1'b1;
          if (bit_end) begin
            cnt <= '0;
            if (!stop_last) begin
              stop_idx <= 1'b1;
            end else if (pop) begin
              shift   <= head;
              bit_idx <= '0;
              state   <= START;
              tx_out  <= 1'b0;
`ifdef UART_TX_PARITY_EN
              par     <= ^head;
`endif
            end else begin
              state  <= IDLE;
              tx_out <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim: reset/idle, single frame, FIFO overflow, parity, mid-frame reset, two stop bits.
module tb_uart_tx_stim;

  localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data, tx_data2;
  logic       tx_valid, tx_valid2;
  logic       tx_ready, tx_out, busy, frame_done;
  logic [3:0] fifo_count;
  logic       tx_ready2, tx_out2, busy2, frame_done2;
  logic [3:0] fifo_count2;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  uart_tx_stim #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy),
    .frame_done(frame_done), .fifo_count(fifo_count)
  );

  uart_tx_stim #(.CLKS_PER_BIT(CPB), .FIFO_AW(3), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_out(tx_out2), .busy(busy2),
    .frame_done(frame_done2), .fifo_count(fifo_count2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered c0 cycles after the start-bit edge; leaves on the first cycle after the frame.
  task automatic rx_frame(input bit sel, input logic [7:0] b, input int nstop,
                          input int c0, input string tag);
    int          len, glitch, fd_cnt, fd_at;
    logic [15:0] bits;
    logic        line, fd;
    len    = (10 + PBITS + nstop - 1) * CPB;
    bits   = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (PBITS == 1) bits[9] = ^b;
    glitch = 0;
    fd_cnt = 0;
    fd_at  = -1;
    for (int c = c0; c < len; c++) begin
      line = sel ? tx_out2 : tx_out;
      fd   = sel ? frame_done2 : frame_done;
      if (c % CPB == CPB / 2)
        chk($sformatf("%s bit%0d", tag, c / CPB), {31'd0, line}, {31'd0, bits[c / CPB]});
      else if (line !== bits[c / CPB])
        glitch++;
      if (fd === 1'b1) begin
        fd_cnt++;
        fd_at = c;
      end
      tick();
    end
    chk({tag, " glitch"}, glitch, 0);
    chk({tag, " fd_count"}, fd_cnt, 1);
    chk({tag, " fd_cycle"}, fd_at, len - 1);
  endtask

  initial begin
    int bad, lows, fds, busies;
    rst = 1'b1;
    tx_data = '0;  tx_valid = 1'b0;
    tx_data2 = '0; tx_valid2 = 1'b0;

    repeat (10) tick();
    chk("rst tx_out", tx_out, 1);
    chk("rst tx_out2", tx_out2, 1);
    rst = 1'b0;
    tick();
    chk("post tx_out", tx_out, 1);
    chk("post tx_ready", tx_ready, 1);
    chk("post busy", busy, 0);
    chk("post fifo_count", fifo_count, 0);
    chk("post frame_done", frame_done, 0);
    chk("post tx_ready2", tx_ready2, 1);

    bad = 0;
    for (int i = 0; i < 5000; i++) begin
      if (tx_out !== 1'b1 || tx_out2 !== 1'b1) bad++;
      tick();
    end
    chk("idle line low cycles", bad, 0);

    // Single byte 0xA5
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("a5 count after push", fifo_count, 1);
    chk("a5 no bypass", tx_out, 1);
    chk("a5 busy", busy, 1);
    tick();
    chk("a5 latency tx_out", tx_out, 0);
    chk("a5 count after pop", fifo_count, 0);
    rx_frame(1'b0, 8'hA5, 1, 0, "a5");
    chk("a5 end tx_out", tx_out, 1);
    chk("a5 end busy", busy, 0);

    // Overflow: 10 pushes on consecutive cycles
    for (int i = 0; i < 10; i++) begin
      tx_data = 8'(i);
      tx_valid = 1'b1;
      chk($sformatf("ovf ready%0d", i), tx_ready, (i < 9) ? 1 : 0);
      tick();
      chk($sformatf("ovf count%0d", i), fifo_count, (i == 0) ? 1 : ((i > 8) ? 8 : i));
    end
    tx_valid = 1'b0;
    rx_frame(1'b0, 8'h00, 1, 8, "ovf0");
    for (int k = 1; k < 9; k++) rx_frame(1'b0, 8'(k), 1, 0, $sformatf("ovf%0d", k));
    chk("ovf end busy", busy, 0);
    chk("ovf end count", fifo_count, 0);
    chk("ovf end tx_out", tx_out, 1);

`ifdef UART_TX_PARITY_EN
    tx_data = 8'h07; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    rx_frame(1'b0, 8'h07, 1, 0, "par07");
`endif

    // Reset during data bit 3 of 0x3C with three bytes queued
    tx_valid = 1'b1;
    tx_data = 8'h3C; tick();
    tx_data = 8'h01; tick();
    tx_data = 8'h02; tick();
    tx_data = 8'h03; tick();
    tx_valid = 1'b0;
    repeat (4 * CPB + CPB / 2 - 2) tick();
    chk("mid bit3 level", tx_out, 1);
    chk("mid queued", fifo_count, 3);
    #5 rst = 1'b1;
    #1;
    chk("mid rst tx_out", tx_out, 1);
    chk("mid rst count", fifo_count, 0);
    chk("mid rst busy", busy, 0);
    chk("mid rst ready", tx_ready, 1);
    chk("mid rst frame_done", frame_done, 0);
    tick();
    rst = 1'b0;
    lows = 0; fds = 0; busies = 0;
    for (int i = 0; i < 3000; i++) begin
      if (tx_out !== 1'b1) lows++;
      if (frame_done !== 1'b0) fds++;
      if (busy !== 1'b0) busies++;
      tick();
    end
    chk("after rst low cycles", lows, 0);
    chk("after rst frame_done", fds, 0);
    chk("after rst busy", busies, 0);

    // Two stop bits, two queued bytes
    tx_valid2 = 1'b1;
    tx_data2 = 8'h55; tick();
    tx_data2 = 8'hAA; tick();
    tx_valid2 = 1'b0;
    chk("stop2 queued", fifo_count2, 1);
    rx_frame(1'b1, 8'h55, 2, 0, "stop2 55");
    rx_frame(1'b1, 8'hAA, 2, 0, "stop2 aa");
    chk("stop2 end tx_out", tx_out2, 1);
    chk("stop2 end busy", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
